// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sequencer sharing one ALU between two requesters (ALU_ARB_LOCK_EN adds req lock inputs).
// Latency: accept at edge T, result captured at T+1, response valid from T+2; one operation in flight.
// Backpressure: req ready only in IDLE for the granted port; response held until the owner's rsp ready.
module alu_arbiter #(
    parameter int WIDTH = 64,
    parameter int CTRW  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [CTRW-1:0]  req0_ctr,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [CTRW-1:0]  req1_ctr,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
`ifdef ALU_ARB_LOCK_EN
    input  logic             req0_lock,
    input  logic             req1_lock,
`endif
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_out,
    output logic             rsp0_zero,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_out,
    output logic             rsp1_zero,
    output logic [CTRW-1:0]  alu_ctr,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t           state, state_nxt;
    logic             prio, owner, lock_q;
    logic             grant, accept, release_op, sel_lock;
    logic [WIDTH-1:0] out0_q, out1_q;
    logic             zero0_q, zero1_q;

    // prio only breaks ties; a lone valid requester always wins
    assign grant      = (req0_valid && req1_valid) ? prio : req1_valid;
    assign accept     = (state == IDLE) && (req0_valid || req1_valid);
    assign release_op = (state == RESP) && (owner ? rsp1_ready : rsp0_ready);

`ifdef ALU_ARB_LOCK_EN
    assign sel_lock = grant ? req1_lock : req0_lock;
`else
    assign sel_lock = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = accept && !grant;
                req1_ready = accept && grant;
                if (accept) state_nxt = EXEC;
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                rsp0_valid = !owner;
                rsp1_valid = owner;
                if (release_op) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // per-port result registers so each response holds its own last value
    always_ff @(posedge clk) begin
        if (reset) begin
            prio    <= 1'b0;
            owner   <= 1'b0;
            lock_q  <= 1'b0;
            alu_ctr <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            out0_q  <= '0;
            out1_q  <= '0;
            zero0_q <= 1'b0;
            zero1_q <= 1'b0;
        end else begin
            if (accept) begin
                owner   <= grant;
                lock_q  <= sel_lock;
                alu_ctr <= grant ? req1_ctr : req0_ctr;
                alu_a   <= grant ? req1_a   : req0_a;
                alu_b   <= grant ? req1_b   : req0_b;
            end
            if (state == EXEC) begin
                if (owner) begin
                    out1_q  <= alu_out;
                    zero1_q <= alu_zero;
                end else begin
                    out0_q  <= alu_out;
                    zero0_q <= alu_zero;
                end
            end
            if (release_op) prio <= lock_q ? owner : ~owner;
        end
    end

    assign rsp0_out  = out0_q;
    assign rsp0_zero = zero0_q;
    assign rsp1_out  = out1_q;
    assign rsp1_zero = zero1_q;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: vector table, corner sequences and random traffic against a transaction-level model.
module tb_alu_arbiter;

`ifdef ALU_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_ctr, req1_ctr, alu_ctr;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_lock, req1_lock;
    logic        rsp0_valid, rsp0_ready, rsp0_zero, rsp1_valid, rsp1_ready, rsp1_zero;
    logic [63:0] rsp0_out, rsp1_out, alu_a, alu_b, alu_out;
    logic        alu_zero, busy;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(64), .CTRW(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctr(req0_ctr), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctr(req1_ctr), .req1_a(req1_a), .req1_b(req1_b),
`ifdef ALU_ARB_LOCK_EN
        .req0_lock(req0_lock), .req1_lock(req1_lock),
`endif
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_out(rsp0_out), .rsp0_zero(rsp0_zero),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_out(rsp1_out), .rsp1_zero(rsp1_zero),
        .alu_ctr(alu_ctr), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .alu_zero(alu_zero),
        .busy(busy)
    );

    function automatic logic [63:0] alu_ref(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
        case (c)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd6:    return a - b;
            4'd7:    return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'd12:   return ~(a | b);
            default: return 64'd0;
        endcase
    endfunction

    // stand-in for the shared ALU
    always_comb begin
        alu_out  = alu_ref(alu_ctr, alu_a, alu_b);
        alu_zero = (alu_out == 64'd0);
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // model: one outstanding op, visible as a response two cycles after acceptance
    bit          m_busy, m_owner, m_prio, m_lock;
    int          acc_cyc;
    logic [63:0] m_res, m_aa, m_ab;
    logic [3:0]  m_actr;
    logic [63:0] m_last_out [2];
    logic        m_last_zero [2];

    logic        s_r0, s_r1, s_v0, s_v1, s_z0, s_z1, s_busy;
    logic [63:0] s_out0, s_out1;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_prio = 0; m_lock = 0; acc_cyc = 0;
        m_res = '0; m_aa = '0; m_ab = '0; m_actr = '0;
        m_last_out[0] = '0; m_last_out[1] = '0;
        m_last_zero[0] = 1'b0; m_last_zero[1] = 1'b0;
    endtask

    task automatic check();
        logic any, g, in_rsp;
        any    = req0_valid || req1_valid;
        g      = (req0_valid && req1_valid) ? m_prio : req1_valid;
        in_rsp = m_busy && (cyc - acc_cyc >= 2);
        cmp("req0_ready", {63'd0, req0_ready}, {63'd0, !m_busy && any && !g});
        cmp("req1_ready", {63'd0, req1_ready}, {63'd0, !m_busy && any && g});
        cmp("rsp0_valid", {63'd0, rsp0_valid}, {63'd0, in_rsp && !m_owner});
        cmp("rsp1_valid", {63'd0, rsp1_valid}, {63'd0, in_rsp && m_owner});
        cmp("rsp0_out", rsp0_out, (in_rsp && !m_owner) ? m_res : m_last_out[0]);
        cmp("rsp1_out", rsp1_out, (in_rsp && m_owner) ? m_res : m_last_out[1]);
        cmp("rsp0_zero", {63'd0, rsp0_zero}, {63'd0, (in_rsp && !m_owner) ? (m_res == 0) : m_last_zero[0]});
        cmp("rsp1_zero", {63'd0, rsp1_zero}, {63'd0, (in_rsp && m_owner) ? (m_res == 0) : m_last_zero[1]});
        cmp("busy", {63'd0, busy}, {63'd0, m_busy});
        cmp("alu_ctr", {60'd0, alu_ctr}, {60'd0, m_actr});
        cmp("alu_a", alu_a, m_aa);
        cmp("alu_b", alu_b, m_ab);
    endtask

    task automatic update();
        logic any, g;
        any = req0_valid || req1_valid;
        g   = (req0_valid && req1_valid) ? m_prio : req1_valid;
        if (reset) begin
            model_reset();
        end else if (!m_busy) begin
            if (any) begin
                m_busy  = 1; acc_cyc = cyc; m_owner = g;
                m_actr  = g ? req1_ctr : req0_ctr;
                m_aa    = g ? req1_a : req0_a;
                m_ab    = g ? req1_b : req0_b;
                m_res   = alu_ref(m_actr, m_aa, m_ab);
                m_lock  = LOCK_EN && (g ? req1_lock : req0_lock);
            end
        end else if ((cyc - acc_cyc >= 2) && (m_owner ? rsp1_ready : rsp0_ready)) begin
            m_busy = 0;
            m_last_out[m_owner]  = m_res;
            m_last_zero[m_owner] = (m_res == 0);
            m_prio = m_lock ? m_owner : !m_owner;
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        s_r0 = req0_ready; s_r1 = req1_ready; s_v0 = rsp0_valid; s_v1 = rsp1_valid;
        s_out0 = rsp0_out; s_out1 = rsp1_out; s_z0 = rsp0_zero; s_z1 = rsp1_zero; s_busy = busy;
        check();
        @(posedge clk);
        update();
        #1;
    endtask

    task automatic idle();
        req0_valid = 0; req1_valid = 0; req0_ctr = '0; req1_ctr = '0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0; req0_lock = 0; req1_lock = 0;
    endtask

    task automatic drive(input bit p, input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
        if (p) begin req1_valid = 1; req1_ctr = c; req1_a = a; req1_b = b; end
        else   begin req0_valid = 1; req0_ctr = c; req0_a = a; req0_b = b; end
    endtask

    task automatic do_reset();
        reset = 1; step(); reset = 0;
    endtask

    typedef struct {
        bit          port;
        logic [3:0]  ctr;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] out;
        logic        zero;
    } vec_t;

    vec_t tbl [9];
    localparam logic [3:0] CODES [6] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};

    initial begin
        bit found;
        bit grants [$];
        int n0;

        tbl[0] = '{1'b0, 4'd2,  64'd5,      64'd7,  64'd12, 1'b0};
        tbl[1] = '{1'b0, 4'd6,  64'd9,      64'd9,  64'd0,  1'b1};
        tbl[2] = '{1'b1, 4'd1,  64'hF0,     64'h0F, 64'hFF, 1'b0};
        tbl[3] = '{1'b1, 4'd7,  64'd3,      64'd4,  64'd1,  1'b0};
        tbl[4] = '{1'b0, 4'd5,  64'hFFFF,   64'd1,  64'd0,  1'b1};
        tbl[5] = '{1'b1, 4'd12, 64'd0,      64'd0,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        tbl[6] = '{1'b0, 4'd6,  64'd0,      64'd1,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        tbl[7] = '{1'b1, 4'd7,  64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd1, 1'b0};
        tbl[8] = '{1'b0, 4'd0,  64'hF0F0,   64'h0FF0, 64'h00F0, 1'b0};

        idle(); rsp0_ready = 0; rsp1_ready = 0; reset = 1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        reset = 0;
        step();  // reset-state comparisons via the model

        // vector table: single requester, response taken immediately
        rsp0_ready = 1; rsp1_ready = 1;
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].port, tbl[i].ctr, tbl[i].a, tbl[i].b);
            step();
            cmp("tbl_accept", {63'd0, tbl[i].port ? s_r1 : s_r0}, 64'd1);
            idle();
            found = 0;
            for (int k = 0; k < 8 && !found; k++) begin
                step();
                if (tbl[i].port ? s_v1 : s_v0) begin
                    found = 1;
                    cmp("tbl_latency", k, 1);
                    cmp("tbl_out", tbl[i].port ? s_out1 : s_out0, tbl[i].out);
                    cmp("tbl_zero", {63'd0, tbl[i].port ? s_z1 : s_z0}, {63'd0, tbl[i].zero});
                    cmp("tbl_other_valid", {63'd0, tbl[i].port ? s_v0 : s_v1}, 64'd0);
                end
            end
            if (!found) begin
                n_vec++; n_err++;
                $display("FAIL tbl_timeout vec=%0d actual=no_rsp required=rsp", i);
            end
            step();
        end

        // both requesters valid from reset: strict alternation
        do_reset();
        drive(0, 4'd6, 64'd9, 64'd9);
        drive(1, 4'd1, 64'hF0, 64'h0F);
        grants.delete();
        for (int k = 0; k < 13; k++) begin
            step();
            if (s_r0) grants.push_back(1'b0);
            if (s_r1) grants.push_back(1'b1);
            if (s_v0) begin cmp("alt_out0", s_out0, 64'd0); cmp("alt_zero0", {63'd0, s_z0}, 64'd1); end
            if (s_v1) begin cmp("alt_out1", s_out1, 64'hFF); cmp("alt_zero1", {63'd0, s_z1}, 64'd0); end
        end
        cmp("alt_count", grants.size(), 5);
        for (int k = 0; k < 4 && k < grants.size(); k++)
            cmp("alt_grant", {63'd0, grants[k]}, {63'd0, k[0]});
        idle(); step(); step(); step();

        // response backpressure on port 1 while port 0 waits
        do_reset();
        rsp1_ready = 0;
        drive(1, 4'd7, 64'd3, 64'd4);
        step();
        cmp("hold_accept", {63'd0, s_r1}, 64'd1);
        idle();
        drive(0, 4'd2, 64'd1, 64'd1);
        step();
        for (int k = 0; k < 5; k++) begin
            step();
            cmp("hold_valid", {63'd0, s_v1}, 64'd1);
            cmp("hold_out", s_out1, 64'd1);
            cmp("hold_req0_ready", {63'd0, s_r0}, 64'd0);
        end
        rsp1_ready = 1;
        step();
        step();
        cmp("hold_after_idle", {63'd0, s_busy}, 64'd0);
        cmp("hold_req0_grant", {63'd0, s_r0}, 64'd1);
        idle(); step(); step(); step();

        // reset during EXEC after port 0 already owned priority once
        drive(0, 4'd2, 64'd1, 64'd2); step(); idle(); step(); step(); step();
        drive(0, 4'd2, 64'd10, 64'd20); step(); idle();
        reset = 1; step(); reset = 0;
        cmp("rst_no_rsp0", {63'd0, s_v0}, 64'd0);
        drive(1, 4'd1, 64'd6, 64'd1);
        step();
        cmp("rst_busy", {63'd0, s_busy}, 64'd0);
        cmp("rst_no_rsp0b", {63'd0, s_v0}, 64'd0);
        cmp("rst_req1_grant", {63'd0, s_r1}, 64'd1);
        cmp("rst_out0", s_out0, 64'd0);
        idle(); step(); step(); step();
        // priority returns to port 0 after a reset mid-operation
        drive(0, 4'd2, 64'd1, 64'd1); step(); idle(); step(); step(); step();
        drive(0, 4'd2, 64'd3, 64'd3); step(); idle();
        reset = 1; step(); reset = 0;
        drive(0, 4'd2, 64'd4, 64'd4); drive(1, 4'd2, 64'd8, 64'd8);
        step();
        cmp("rst_prio0", {63'd0, s_r0}, 64'd1);
        idle(); step(); step(); step();

`ifdef ALU_ARB_LOCK_EN
        // lock keeps port 0 in front of a waiting port 1
        do_reset();
        drive(0, 4'd2, 64'd1, 64'd1);
        drive(1, 4'd1, 64'd2, 64'd1);
        grants.delete();
        n0 = 0;
        for (int k = 0; k < 12; k++) begin
            req0_lock = (n0 == 0);
            step();
            if (s_r0) begin grants.push_back(1'b0); n0++; end
            if (s_r1) grants.push_back(1'b1);
        end
        cmp("lock_count", grants.size(), 4);
        if (grants.size() >= 3) begin
            cmp("lock_g0", {63'd0, grants[0]}, 64'd0);
            cmp("lock_g1", {63'd0, grants[1]}, 64'd0);
            cmp("lock_g2", {63'd0, grants[2]}, 64'd1);
        end
        idle(); step(); step(); step();
`else
        n0 = 0;
`endif

        // random traffic against the model
        for (int k = 0; k < 2000; k++) begin
            int r;
            reset      = ($urandom_range(0, 59) == 0);
            req0_valid = ($urandom_range(0, 9) < 6);
            req1_valid = ($urandom_range(0, 9) < 6);
            r = $urandom_range(0, 7);
            req0_ctr = (r < 6) ? CODES[r] : 4'($urandom_range(0, 15));
            r = $urandom_range(0, 7);
            req1_ctr = (r < 6) ? CODES[r] : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                req0_a = 64'($urandom_range(0, 3)); req0_b = 64'($urandom_range(0, 3));
                req1_a = 64'($urandom_range(0, 3)); req1_b = 64'($urandom_range(0, 3));
            end else begin
                req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom};
                req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom};
            end
            req0_lock  = $urandom_range(0, 1) == 1;
            req1_lock  = $urandom_range(0, 1) == 1;
            rsp0_ready = $urandom_range(0, 1) == 1;
            rsp1_ready = $urandom_range(0, 1) == 1;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Sequencer and arbiter that shares one alu_64 instance between two requesters.
  - Port 0: main execute path.
  - Port 1: branch/address unit.
- Accepts one operation at a time over a valid/ready handshake and grants round-robin.
- Drives the ALU from registered operands, captures Out/Zero, and returns them on the owner's response channel.
- Sits between the decode/execute control and the single shared 64-bit ALU.

Parameters:
- WIDTH, 64, operand/result width
- CTRW, 4, ALU control code width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  arbiter accepts requester 0 this cycle
- req0_ctr  input  CTRW  ALU control code, requester 0
- req0_a  input  WIDTH  operand A, requester 0
- req0_b  input  WIDTH  operand B, requester 0
- req1_valid, req1_ready, req1_ctr, req1_a, req1_b: as above, requester 1
- rsp0_valid  output  1  result available for requester 0
- rsp0_ready  input  1  requester 0 consumes result
- rsp0_out  output  WIDTH  result for requester 0
- rsp0_zero  output  1  zero flag for requester 0
- rsp1_valid, rsp1_ready, rsp1_out, rsp1_zero: as above, requester 1
- alu_ctr  output  CTRW  to ALU ALUctr
- alu_a  output  WIDTH  to ALU A
- alu_b  output  WIDTH  to ALU B
- alu_out  input  WIDTH  from ALU Out
- alu_zero  input  1  from ALU Zero
- busy  output  1  state != IDLE

Behaviour:
- One clock domain (clk). reset is synchronous, active-high.
- FSM states: IDLE, EXEC, RESP. State, owner, pointer, operand and result registers are all flops.
- IDLE:
  - Grant is combinational from req*_valid and pointer prio.
  - Both valid: grant req[prio]. Only one valid: grant it.
  - reqN_ready = 1 only for the granted requester, and only in IDLE; the other ready stays 0.
  - On valid&ready: latch ctr/a/b into alu_ctr/alu_a/alu_b, record owner, go to EXEC.
  - No valid: stay in IDLE with alu_* held.
- EXEC (one cycle):
  - ALU sees stable registered operands.
  - At the clock edge, capture alu_out/alu_zero into the result register and go to RESP.
- RESP:
  - rsp[owner]_valid = 1 with rsp[owner]_out/_zero from the result register. The other rsp_valid is 0.
  - Hold until rsp[owner]_ready = 1.
  - That edge: go to IDLE and set prio = ~owner.
- req_ready is never asserted in EXEC or RESP. Single outstanding operation.
- Latency: accept at edge T, result captured at T+1, rsp_valid high from T+2 (2-cycle minimum). Maximum throughput is one op per 3 cycles.
- rspN_out/rspN_zero hold their last value when not valid. rsp_valid is never asserted for a non-owner.
- Control codes are forwarded unmodified. The ALU decides semantics: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR, others give 0, so the result is 0 and zero = 1.
- Requester may drop valid before acceptance with no effect. Operands are sampled only on the accepting edge.
- rsp_ready asserted outside RESP is ignored.
- Reset values:
  - state IDLE, prio 0, owner 0
  - alu_ctr 0, alu_a 0, alu_b 0
  - result 0, zero 0
  - all ready/valid 0, busy 0
- Reset mid-operation (EXEC or RESP): operation discarded, no response issued, prio returns to 0.

Optional Feature:
- Macro ALU_ARB_LOCK_EN.
- Defined:
  - Adds inputs req0_lock and req1_lock (1 bit each), sampled with the accepted request.
  - If the accepted request had lock = 1, then on leaving RESP, prio = owner instead of ~owner. The owner keeps priority for back-to-back multi-op sequences while the other requester waits.
  - A request accepted with lock = 0 releases it.
- Not defined: lock ports absent, strict alternation as above.

Test Plan:
- req0 only, ctr=2, a=5, b=7, rsp0_ready=1 -> req0_ready in cycle 0; rsp0_valid in cycle 2 with out=12, zero=0; rsp1_valid stays 0; busy high for 2 cycles.
- Both valid every cycle from reset, req0 SUB a=9 b=9, req1 OR a=0xF0 b=0x0F -> grants alternate 0,1,0,1; rsp0 out=0 zero=1; rsp1 out=0xFF zero=0.
- req1 SLT a=3 b=4 with rsp1_ready held 0 for 5 cycles -> rsp1_valid and out=1 stable for 5 cycles; req0_ready stays 0 throughout; IDLE after the ready edge.
- reset asserted during EXEC of req0 ADD -> no rsp0_valid; all outputs return to reset values next cycle; a following req1 is granted first.
- ctr=5 (unsupported), a=0xFFFF, b=1 -> out=0, zero=1, handshake identical to a legal op.
- ALU_ARB_LOCK_EN: req0 lock=1 for 2 ops with req1 valid throughout -> req0 granted twice, then req1 granted after the req0 op with lock=0.
